// File: rtl/writeback_arbiter.sv
// Writeback stage: merges buffered ALU results and extended load responses into
// one registered register-file write per cycle, with x0 suppression and ALU fairness.
module writeback_arbiter #(
  parameter int XLEN           = 32,
  parameter int ALU_FIFO_DEPTH = 2
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   alu_valid,
  output logic                                   alu_ready,
  input  logic [4:0]                             alu_rd,
  input  logic [XLEN-1:0]                        alu_data,
  input  logic                                   ld_valid,
  output logic                                   ld_ready,
  input  logic [4:0]                             ld_rd,
  input  logic [2:0]                             ld_funct3,
  input  logic [1:0]                             ld_addr_lo,
  input  logic [XLEN-1:0]                        ld_rdata,
  output logic                                   reg_write,
  output logic [4:0]                             rd,
  output logic [XLEN-1:0]                        write_data,
  output logic [$clog2(ALU_FIFO_DEPTH+1)-1:0]    alu_fifo_count
);

  localparam int CNT_W = $clog2(ALU_FIFO_DEPTH + 1);
  localparam int PTR_W = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(ALU_FIFO_DEPTH);

  logic [4:0]       fifo_rd   [ALU_FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_data [ALU_FIFO_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             last_was_load;

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             grant_ld_p0;
  logic             grant_alu_p0;
  logic             vld_p0;
  logic [4:0]       rd_p0;
  logic [XLEN-1:0]  data_p0;

  // Byte/halfword/word select and extension of a raw memory word.
  function automatic logic [XLEN-1:0] extend_load(input logic [2:0]      funct3,
                                                  input logic [1:0]      addr_lo,
                                                  input logic [XLEN-1:0] rdata);
    logic [XLEN-1:0]   byte_sh;
    logic [XLEN-1:0]   half_sh;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] word_s;
    logic [XLEN-1:0]   ext;
    byte_sh = rdata >> {addr_lo, 3'b000};
    half_sh = rdata >> {addr_lo[1], 4'b0000};
    byte_s  = byte_sh[7:0];
    half_s  = half_sh[15:0];
    word_s  = rdata[31:0];
    case (funct3)
      3'b000:  ext = XLEN'(byte_s);
      3'b100:  ext = XLEN'(byte_sh[7:0]);
      3'b001:  ext = XLEN'(half_s);
      3'b101:  ext = XLEN'(half_sh[15:0]);
      3'b010:  ext = XLEN'(word_s);
      default: ext = '0;
    endcase
    return ext;
  endfunction

  assign fifo_full      = (count == DEPTH_C);
  assign fifo_empty     = (count == '0);
  assign alu_ready      = (count < DEPTH_C);
  assign ld_ready       = !(fifo_full && last_was_load);
  assign alu_fifo_count = count;

  assign push         = alu_valid && alu_ready;
  assign grant_ld_p0  = ld_valid && ld_ready;
  assign grant_alu_p0 = !grant_ld_p0 && !fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      last_was_load <= 1'b0;
    end else begin
      if (push)         tail <= tail + PTR_W'(1);
      if (grant_alu_p0) head <= head + PTR_W'(1);
      case ({push, grant_alu_p0})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (grant_ld_p0)       last_was_load <= 1'b1;
      else if (grant_alu_p0) last_was_load <= 1'b0;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by head/tail/count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[tail]   <= alu_rd;
      fifo_data[tail] <= alu_data;
    end
  end

  // Stage p0: select the granted source and drop x0 destinations.
  always_comb begin
    rd_p0   = '0;
    data_p0 = '0;
    if (grant_ld_p0) begin
      rd_p0   = ld_rd;
      data_p0 = extend_load(ld_funct3, ld_addr_lo, ld_rdata);
    end else if (grant_alu_p0) begin
      rd_p0   = fifo_rd[head];
      data_p0 = fifo_data[head];
    end
    vld_p0 = (grant_ld_p0 || grant_alu_p0) && (rd_p0 != 5'd0);
  end

  // Stage p1: register-file write port, reloaded every edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_write  <= 1'b0;
      rd         <= '0;
      write_data <= '0;
    end else if (vld_p0) begin
      reg_write  <= 1'b1;
      rd         <= rd_p0;
      write_data <= data_p0;
    end else begin
      reg_write  <= 1'b0;
      rd         <= '0;
      write_data <= '0;
    end
  end

endmodule
